// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..DATA_W data bits, optional parity, 1/2 stop bits, 3-sample majority vote.
// Define RX_SYNC_EN to pass RX_IN through a 2-flop synchroniser (adds 2 cycles of latency).
module uart_rx_cfg #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               nRESET,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic [4:0]         DATA_LEN,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic               STOP2,
    output logic               data_valid,
    output logic [DATA_W-1:0]  P_DATA,
    output logic               par_err,
    output logic               stp_err
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_e;

    localparam logic [4:0] MAX_LEN = 5'(DATA_W);

    logic rx;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_IN};
        end
    end

    assign rx = sync_q[1];
`else
    assign rx = RX_IN;
`endif

    state_e              state_q, state_d;
    logic [PRESC_W-1:0]  edge_q, edge_d;
    logic [4:0]          bit_q, bit_d;
    logic [4:0]          len_q, len_d;
    logic                par_en_q, par_en_d;
    logic                par_typ_q, par_typ_d;
    logic                stop2_q, stop2_d;
    logic [2:0]          samp_q, samp_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_fail_q, par_fail_d;
    logic                stp_fail_q, stp_fail_d;
    logic [DATA_W-1:0]   pdata_q, pdata_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                serr_q, serr_d;

    logic [PRESC_W-1:0]  mid;
    logic                edge_wrap;
    logic                sample_ok;
    logic                maj;
    logic [4:0]          cfg_len;
    logic                exp_par;
    logic [4:0]          last_stop;

    assign mid       = Prescale >> 1;
    assign edge_wrap = (edge_q == Prescale - PRESC_W'(1));
    assign sample_ok = (edge_q == mid + PRESC_W'(2));
    assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    assign cfg_len   = (DATA_LEN < 5'd5 || DATA_LEN > MAX_LEN) ? MAX_LEN : DATA_LEN;
    assign exp_par   = (^shift_q) ^ par_typ_q;
    assign last_stop = len_q + {4'b0, par_en_q} + 5'd1 + {4'b0, stop2_q};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        stop2_d    = stop2_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        par_fail_d = par_fail_q;
        stp_fail_d = stp_fail_q;
        pdata_d    = pdata_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        serr_d     = 1'b0;

        if (edge_wrap) begin
            edge_d = '0;
            bit_d  = bit_q + 5'd1;
        end else begin
            edge_d = edge_q + PRESC_W'(1);
            bit_d  = bit_q;
        end

        if (edge_q == mid - PRESC_W'(1)) samp_d[0] = rx;
        if (edge_q == mid)               samp_d[1] = rx;
        if (edge_q == mid + PRESC_W'(1)) samp_d[2] = rx;

        case (state_q)
            // DONE doubles as IDLE so a start bit right after the stop bit is not missed.
            IDLE, DONE: begin
                edge_d = '0;
                bit_d  = '0;
                if (!rx) begin
                    state_d    = START;
                    len_d      = cfg_len;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    stop2_d    = STOP2;
                    shift_d    = '0;
                    par_fail_d = 1'b0;
                    stp_fail_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (sample_ok && maj) begin
                    state_d = IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
                end else if (edge_wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (sample_ok) begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (bit_q == 5'(i + 1)) shift_d[i] = maj;
                    end
                end
                if (edge_wrap && bit_q == len_q) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (sample_ok && (maj != exp_par)) par_fail_d = 1'b1;
                if (edge_wrap) state_d = STOP;
            end
            STOP: begin
                if (sample_ok && !maj) stp_fail_d = 1'b1;
                if (edge_wrap && bit_q == last_stop) begin
                    state_d = DONE;
                    edge_d  = '0;
                    bit_d   = '0;
                    valid_d = !par_fail_q && !stp_fail_q;
                    perr_d  = par_fail_q;
                    serr_d  = stp_fail_q;
                    if (!par_fail_q && !stp_fail_q) pdata_d = shift_q;
                end
            end
            default: begin
                state_d = IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= IDLE;
            edge_q     <= '0;
            bit_q      <= '0;
            len_q      <= MAX_LEN;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            samp_q     <= 3'b111;
            shift_q    <= '0;
            par_fail_q <= 1'b0;
            stp_fail_q <= 1'b0;
            pdata_q    <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            len_q      <= len_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop2_q    <= stop2_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            par_fail_q <= par_fail_d;
            stp_fail_q <= stp_fail_d;
            pdata_q    <= pdata_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
        end
    end

    assign data_valid = valid_q;
    assign P_DATA     = pdata_q;
    assign par_err    = perr_q;
    assign stp_err    = serr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

`ifdef RX_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic [4:0] DATA_LEN = 5'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       STOP2 = 1'b0;
    logic       data_valid;
    logic [7:0] P_DATA;
    logic       par_err;
    logic       stp_err;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    logic [7:0] refP = 8'h00;

    typedef struct {
        bit         v;
        bit         pe;
        bit         se;
        logic [7:0] d;
        int         t;
    } ev_t;

    ev_t evq[$];

    uart_rx_cfg #(.DATA_W(8), .PRESC_W(6)) dut (
        .CLK(CLK), .nRESET(nRESET), .RX_IN(RX_IN), .Prescale(Prescale),
        .DATA_LEN(DATA_LEN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
        .data_valid(data_valid), .P_DATA(P_DATA), .par_err(par_err), .stp_err(stp_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    // Every strobe seen on the falling edge is logged for the scenario tasks to inspect.
    always @(negedge CLK) begin : monitor
        ev_t e;
        if (nRESET && (data_valid === 1'b1 || par_err === 1'b1 || stp_err === 1'b1)) begin
            e.v  = data_valid;
            e.pe = par_err;
            e.se = stp_err;
            e.d  = P_DATA;
            e.t  = cyc;
            evq.push_back(e);
        end
    end

    function automatic ev_t evAt(input int idx);
        ev_t e;
        e.v = 1'b0; e.pe = 1'b0; e.se = 1'b0; e.d = 8'hxx; e.t = -1;
        if (idx < evq.size()) e = evq[idx];
        return e;
    endfunction

    // Frame-level reference: what the receiver should report for a given bit pattern.
    function automatic void modelFrame(input logic [7:0] d, input int len, input bit pe, input bit pt,
                                       input bit pbit, input bit s1, input bit s2en, input bit s2,
                                       inout logic [7:0] pdata, output bit ev, output bit ep, output bit es);
        int eff;
        logic [7:0] dm;
        eff = (len < 5 || len > 8) ? 8 : len;
        dm  = d & 8'((1 << eff) - 1);
        ep  = pe && (pbit != ((^dm) ^ pt));
        es  = !s1 || (s2en && !s2);
        ev  = !ep && !es;
        if (ev) pdata = dm;
    endfunction

    task automatic send_frame(input int p, input logic [7:0] d, input int n, input bit hasPar,
                              input bit pbit, input bit s1, input bit hasS2, input bit s2, input bit scramble);
        bit q[$];
        logic [4:0] savedLen;
        logic savedPe, savedS2;
        savedLen = DATA_LEN; savedPe = PAR_EN; savedS2 = STOP2;
        Prescale = 6'(p);
        q.push_back(1'b0);
        for (int i = 0; i < n; i++) q.push_back(d[i]);
        if (hasPar) q.push_back(pbit);
        q.push_back(s1);
        if (hasS2) q.push_back(s2);
        for (int i = 0; i < q.size(); i++) begin
            if (scramble && i == 3) begin
                DATA_LEN = 5'd5; PAR_EN = ~savedPe; STOP2 = ~savedS2;
            end
            if (scramble && i == q.size() - 1) begin
                DATA_LEN = savedLen; PAR_EN = savedPe; STOP2 = savedS2;
            end
            RX_IN = q[i];
            repeat (p) @(posedge CLK);
            #1;
        end
        RX_IN = 1'b1;
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (data_valid !== 1'b0) $display("[TB] FAIL reset_valid got=%b exp=0", data_valid); else passes++;
        checks++; if (par_err !== 1'b0) $display("[TB] FAIL reset_par_err got=%b exp=0", par_err); else passes++;
        checks++; if (stp_err !== 1'b0) $display("[TB] FAIL reset_stp_err got=%b exp=0", stp_err); else passes++;
        checks++; if (P_DATA !== 8'h00) $display("[TB] FAIL reset_pdata got=%h exp=00", P_DATA); else passes++;
        nRESET = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        checks++; if (evq.size() !== 0) $display("[TB] FAIL reset_idle_events got=%0d exp=0", evq.size()); else passes++;
        evq.delete();
    endtask

    task automatic test_basic();
        int t0;
        ev_t e;
        DATA_LEN = 5'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        evq.delete();
        t0 = cyc;
        send_frame(8, 8'hA5, 8, 0, 0, 1, 0, 1, 0);
        repeat (8) @(posedge CLK);
        #1;
        e = evAt(0);
        checks++; if (evq.size() !== 1) $display("[TB] FAIL basic_count got=%0d exp=1", evq.size()); else passes++;
        checks++; if (e.v !== 1'b1) $display("[TB] FAIL basic_valid got=%b exp=1", e.v); else passes++;
        checks++; if (e.d !== 8'hA5) $display("[TB] FAIL basic_data got=%h exp=a5", e.d); else passes++;
        checks++; if ({e.pe, e.se} !== 2'b00) $display("[TB] FAIL basic_errs got=%b exp=00", {e.pe, e.se}); else passes++;
        checks++; if (e.t - t0 !== 81 + SYNC) $display("[TB] FAIL basic_latency got=%0d exp=%0d", e.t - t0, 81 + SYNC); else passes++;
        checks++; if (P_DATA !== 8'hA5) $display("[TB] FAIL basic_hold got=%h exp=a5", P_DATA); else passes++;
        evq.delete();
    endtask

    task automatic test_parity();
        ev_t e;
        DATA_LEN = 5'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
        send_frame(8, 8'h3C, 8, 1, 1, 1, 0, 1, 0);
        repeat (8) @(posedge CLK);
        #1;
        e = evAt(0);
        checks++; if (evq.size() !== 1) $display("[TB] FAIL parity_count got=%0d exp=1", evq.size()); else passes++;
        checks++; if (e.pe !== 1'b1) $display("[TB] FAIL parity_err got=%b exp=1", e.pe); else passes++;
        checks++; if ({e.v, e.se} !== 2'b00) $display("[TB] FAIL parity_others got=%b exp=00", {e.v, e.se}); else passes++;
        checks++; if (P_DATA !== 8'hA5) $display("[TB] FAIL parity_pdata_hold got=%h exp=a5", P_DATA); else passes++;
        evq.delete();
    endtask

    task automatic test_stop2();
        ev_t e;
        DATA_LEN = 5'd5; PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b1;
        // 0x13 has three ones, so the odd-parity bit is 0.
        send_frame(16, 8'h13, 5, 1, 0, 1, 1, 0, 0);
        repeat (10) @(posedge CLK);
        #1;
        e = evAt(0);
        checks++; if (evq.size() !== 1) $display("[TB] FAIL stop2_bad_count got=%0d exp=1", evq.size()); else passes++;
        checks++; if ({e.v, e.pe, e.se} !== 3'b001) $display("[TB] FAIL stop2_bad_flags got=%b exp=001", {e.v, e.pe, e.se}); else passes++;
        checks++; if (P_DATA !== 8'hA5) $display("[TB] FAIL stop2_bad_hold got=%h exp=a5", P_DATA); else passes++;
        evq.delete();
        send_frame(16, 8'h13, 5, 1, 0, 1, 1, 1, 0);
        repeat (10) @(posedge CLK);
        #1;
        e = evAt(0);
        checks++; if (evq.size() !== 1) $display("[TB] FAIL stop2_good_count got=%0d exp=1", evq.size()); else passes++;
        checks++; if ({e.v, e.pe, e.se} !== 3'b100) $display("[TB] FAIL stop2_good_flags got=%b exp=100", {e.v, e.pe, e.se}); else passes++;
        checks++; if (e.d !== 8'h13) $display("[TB] FAIL stop2_good_data got=%h exp=13", e.d); else passes++;
        evq.delete();
    endtask

    task automatic test_glitch();
        ev_t e;
        DATA_LEN = 5'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Prescale = 6'd8;
        RX_IN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RX_IN = 1'b1;
        repeat (40) @(posedge CLK);
        #1;
        checks++; if (evq.size() !== 0) $display("[TB] FAIL glitch_events got=%0d exp=0", evq.size()); else passes++;
        evq.delete();
        send_frame(8, 8'h55, 8, 0, 0, 1, 0, 1, 0);
        repeat (8) @(posedge CLK);
        #1;
        e = evAt(0);
        checks++; if (evq.size() !== 1 || e.v !== 1'b1) $display("[TB] FAIL glitch_next_valid got=%0d/%b exp=1/1", evq.size(), e.v); else passes++;
        checks++; if (e.d !== 8'h55) $display("[TB] FAIL glitch_next_data got=%h exp=55", e.d); else passes++;
        evq.delete();
    endtask

    task automatic test_back_to_back();
        ev_t e0, e1;
        DATA_LEN = 5'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        send_frame(8, 8'h01, 8, 0, 0, 1, 0, 1, 1);
        send_frame(8, 8'hFE, 8, 0, 0, 1, 0, 1, 1);
        repeat (8) @(posedge CLK);
        #1;
        e0 = evAt(0);
        e1 = evAt(1);
        checks++; if (evq.size() !== 2) $display("[TB] FAIL b2b_count got=%0d exp=2", evq.size()); else passes++;
        checks++; if (e0.v !== 1'b1 || e0.d !== 8'h01) $display("[TB] FAIL b2b_first got=%b/%h exp=1/01", e0.v, e0.d); else passes++;
        checks++; if (e1.v !== 1'b1 || e1.d !== 8'hFE) $display("[TB] FAIL b2b_second got=%b/%h exp=1/fe", e1.v, e1.d); else passes++;
        checks++; if (P_DATA !== 8'hFE) $display("[TB] FAIL b2b_pdata got=%h exp=fe", P_DATA); else passes++;
        evq.delete();
    endtask

    task automatic test_mid_reset();
        ev_t e;
        DATA_LEN = 5'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Prescale = 6'd8;
        RX_IN = 1'b0; repeat (8) @(posedge CLK); #1;
        RX_IN = 1'b1; repeat (8) @(posedge CLK); #1;
        RX_IN = 1'b0; repeat (3) @(posedge CLK); #2;
        nRESET = 1'b0;
        #1;
        checks++; if (P_DATA !== 8'h00) $display("[TB] FAIL midrst_pdata got=%h exp=00", P_DATA); else passes++;
        checks++; if ({data_valid, par_err, stp_err} !== 3'b000) $display("[TB] FAIL midrst_strobes got=%b exp=000", {data_valid, par_err, stp_err}); else passes++;
        repeat (3) @(posedge CLK);
        #1;
        RX_IN = 1'b1;
        nRESET = 1'b1;
        repeat (100) @(posedge CLK);
        #1;
        checks++; if (evq.size() !== 0) $display("[TB] FAIL midrst_no_strobe got=%0d exp=0", evq.size()); else passes++;
        evq.delete();
        send_frame(8, 8'h96, 8, 0, 0, 1, 0, 1, 0);
        repeat (8) @(posedge CLK);
        #1;
        e = evAt(0);
        checks++; if (evq.size() !== 1 || e.v !== 1'b1 || e.d !== 8'h96) $display("[TB] FAIL midrst_next got=%0d/%b/%h exp=1/1/96", evq.size(), e.v, e.d); else passes++;
        refP = 8'h96;
        evq.delete();
    endtask

    task automatic test_random();
        int p, len, eff;
        bit pe, pt, pbit, s1, s2en, s2, ev, ep, es;
        logic [7:0] d;
        ev_t e;
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 2))
                0: p = 8;
                1: p = 16;
                default: p = 32;
            endcase
            len  = $urandom_range(0, 31);
            eff  = (len < 5 || len > 8) ? 8 : len;
            pe   = $urandom_range(0, 1);
            pt   = $urandom_range(0, 1);
            s2en = $urandom_range(0, 1);
            d    = 8'($urandom);
            pbit = ((^(d & 8'((1 << eff) - 1))) ^ pt) ^ ($urandom_range(0, 3) == 0);
            s1   = ($urandom_range(0, 4) != 0);
            s2   = ($urandom_range(0, 4) != 0);
            DATA_LEN = 5'(len); PAR_EN = pe; PAR_TYP = pt; STOP2 = s2en;
            send_frame(p, d, eff, pe, pbit, s1, s2en, s2, 0);
            modelFrame(d, len, pe, pt, pbit, s1, s2en, s2, refP, ev, ep, es);
            repeat (8) @(posedge CLK);
            #1;
            e = evAt(0);
            checks++; if (evq.size() !== 1) $display("[TB] FAIL rand%0d_count got=%0d exp=1", k, evq.size()); else passes++;
            checks++; if ({e.v, e.pe, e.se} !== {ev, ep, es}) $display("[TB] FAIL rand%0d_flags got=%b exp=%b", k, {e.v, e.pe, e.se}, {ev, ep, es}); else passes++;
            checks++; if (P_DATA !== refP) $display("[TB] FAIL rand%0d_pdata got=%h exp=%h", k, P_DATA, refP); else passes++;
            evq.delete();
            repeat ($urandom_range(0, 4)) @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        @(posedge CLK);
        #1;
        test_reset();
        test_basic();
        test_parity();
        test_stop2();
        test_glitch();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised, runtime-configurable UART receiver; next generation of the fixed 8-bit receiver in the UART subsystem.
- Adds runtime data length (5..DATA_W), 1 or 2 stop bits, 3-sample majority vote, and configuration latched per frame.
- Deserialises RX_IN at Prescale oversampling and returns a parallel word with one-cycle valid/error strobes to the system controller.
- One FSM with internal edge/bit counters, majority sampler, shift register and parity/stop checkers.

Parameters:
- DATA_W, 8, maximum data bits per frame (legal 5..16).
- PRESC_W, 6, width of Prescale input.

Ports:
- CLK  input  1  oversampling clock (Prescale x baud).
- nRESET  input  1  asynchronous active-low reset.
- RX_IN  input  1  serial line, idle high.
- Prescale  input  PRESC_W  oversampling ratio; legal values 8, 16, 32.
- DATA_LEN  input  5  data bits per frame; values <5 or >DATA_W are treated as DATA_W.
- PAR_EN  input  1  parity bit present.
- PAR_TYP  input  1  0 = even, 1 = odd.
- STOP2  input  1  two stop bits expected.
- data_valid  output  1  one-cycle strobe: error-free frame received.
- P_DATA  output  DATA_W  received word, LSB first; bits at or above DATA_LEN read 0.
- par_err  output  1  one-cycle strobe: parity mismatch.
- stp_err  output  1  one-cycle strobe: stop bit sampled low.

Behaviour:
Reset:
- Async reset on nRESET low. Counters are 0.
- data_valid, par_err and stp_err reset to 0. P_DATA resets to 0.
- FSM resets to IDLE. Reset mid-frame aborts the frame with no strobe.

Configuration latch:
- DATA_LEN, PAR_EN, PAR_TYP and STOP2 are captured on the IDLE->START transition.
- Changes during a frame have no effect on that frame.

Counters:
- edge_cnt runs 0..Prescale-1 and wraps; bit_cnt increments on each wrap.
- Both clear in IDLE.

Sampling:
- RX_IN is sampled at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
- The sampled bit is the majority of the 3 samples and is valid from edge_cnt = Prescale/2+2.

FSM:
- IDLE: RX_IN = 0 -> START; edge_cnt starts at 0 on the next cycle.
- START: if the sampled bit is 1 (glitch) -> IDLE at the sample-valid cycle, no strobes. Else at edge_cnt wrap -> DATA.
- DATA: shift the sampled bit into P_DATA position bit_cnt-1 (LSB first). After DATA_LEN bits -> PARITY if PAR_EN, else STOP.
- PARITY: expected bit = XOR(data bits) ^ PAR_TYP; a mismatch sets an internal parity-fail flag. At wrap -> STOP.
- STOP: a sampled 0 sets an internal stop-fail flag. With STOP2 = 1, both stop bits are checked. At the final stop bit's wrap -> DONE.
- DONE: single cycle.
  - No fail flags: data_valid = 1 and the output register P_DATA updates.
  - Otherwise: par_err and/or stp_err = 1 (both may assert together); data_valid = 0 and P_DATA holds its previous value.
  - Next state is IDLE. If RX_IN = 0 in DONE, go directly to START, so back-to-back frames lose no cycles.

Latency and framing:
- Strobes assert 1 cycle after the final stop bit period ends.
- Frame length in bits = 1 + DATA_LEN + PAR_EN + 1 + STOP2.
- The internal shift register is separate from P_DATA, so P_DATA is stable between valid strobes.

Optional Feature:
RX_SYNC_EN
- Defined: RX_IN passes through a 2-flop synchroniser (reset value 1) before all logic. Every timing above shifts by 2 cycles.
- Undefined: RX_IN is used directly; the driver is required to be synchronous to CLK.

Test Plan:
1. Prescale = 8, DATA_LEN = 8, PAR_EN = 0, STOP2 = 0; send 0xA5 -> one data_valid pulse, P_DATA = 0xA5, no errors, strobe 81 cycles after the start edge (+2 with RX_SYNC_EN).
2. DATA_LEN = 8, PAR_EN = 1, PAR_TYP = 0; send 0x3C with parity bit 1 -> par_err pulse, data_valid = 0, P_DATA keeps previous 0xA5.
3. Prescale = 16, DATA_LEN = 5, PAR_TYP = 1, STOP2 = 1; send 0x13 with odd parity and second stop bit low -> stp_err pulse only; repeat with both stop bits high -> data_valid, P_DATA = 0x13.
4. Start glitch: RX_IN low for 2 cycles at Prescale = 8 -> no strobes, FSM back in IDLE; a following valid 0x55 frame is received correctly.
5. Back-to-back: two 8N1 frames 0x01, 0xFE with no idle gap -> two data_valid pulses carrying 0x01 then 0xFE; toggling DATA_LEN mid-frame does not alter either frame.
6. nRESET asserted in the middle of a DATA bit -> outputs 0 immediately, no strobe; the next frame decodes correctly.
